// File: rtl/global_buffer_param.sv
// Shared CGRA global-buffer parameters: AXI widths, AXI response codes and
// the state encoding of the AXI4-lite configuration sequencer.
package global_buffer_param;

    localparam int CGRA_AXI_ADDR_WIDTH = 32;
    localparam int CGRA_AXI_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP,
        HUNG
    } cfg_seq_state_t;

endpackage

// File: rtl/axil_cfg_sequencer.sv
// AXI4-lite single-outstanding configuration master. Accepts one read or
// write command at a time, runs it on the AXI bus with registered outputs,
// and returns one response. A stalled slave is abandoned after
// TIMEOUT_CYCLES and the sequencer parks in HUNG until reset.
module axil_cfg_sequencer
    import global_buffer_param::*;
#(
    parameter int ADDR_WIDTH     = CGRA_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CGRA_AXI_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    output logic                  busy,
    output logic                  hung
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    cfg_seq_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             aw_done;
    logic             w_done;
    logic             aw_fin;
    logic             w_fin;
    logic             timeout_hit;

    // Command acceptance and status are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // A channel counts as finished once its handshake happened, including this cycle.
    assign aw_fin      = aw_done | (awvalid & awready);
    assign w_fin       = w_done  | (wvalid  & wready);
    assign timeout_hit = (cnt == CNT_LAST);

    // Sequencer FSM: every AXI and response output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= AXI_RESP_OKAY;
            rsp_timeout <= 1'b0;
            hung        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cnt <= '0;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ, WR_RESP, RD_REQ, RD_DATA: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timeout_hit) begin
                        awvalid     <= 1'b0;
                        wvalid      <= 1'b0;
                        bready      <= 1'b0;
                        arvalid     <= 1'b0;
                        rready      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= AXI_RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        state       <= RSP;
                    end else if (state == WR_REQ) begin
                        if (awvalid && awready) begin
                            awvalid <= 1'b0;
                            aw_done <= 1'b1;
                        end
                        if (wvalid && wready) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                        if (aw_fin && w_fin) begin
                            bready <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end else if (state == WR_RESP) begin
                        if (bvalid) begin
                            bready      <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_resp    <= bresp;
                            rsp_timeout <= 1'b0;
                            state       <= RSP;
                        end
                    end else if (state == RD_REQ) begin
                        if (arready) begin
                            arvalid <= 1'b0;
                            rready  <= 1'b1;
                            state   <= RD_DATA;
                        end
                    end else begin
                        if (rvalid) begin
                            rready      <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= rdata;
                            rsp_resp    <= rresp;
                            rsp_timeout <= 1'b0;
                            state       <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_timeout) begin
                            hung  <= 1'b1;
                            state <= HUNG;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HUNG: begin
                    hung <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Scoreboard bench for axil_cfg_sequencer: expected responses are queued
// when a command is issued and compared when the DUT presents rsp_valid.
module tb_axil_cfg_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          timeout;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
    logic          busy, hung;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    axil_cfg_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .busy       (busy),
        .hung       (hung)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    endtask

    // Present one command for a single cycle; on return the DUT is in its first request cycle.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cmd_ready_at_issue: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare against the scoreboard, hold it, then handshake.
    task automatic collect_rsp(input int hold);
        int   waited;
        exp_t e;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rsp_wait: rsp_valid %b after %0d cycles, want 1", rsp_valid, waited);
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL rsp_unexpected: got a response, scoreboard has 0 entries want >=1");
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp
                || rsp_timeout !== e.timeout) begin
                n_fail++;
                $display("[TB] FAIL rsp_payload[%0d]: got v=%b d=%h r=%b t=%b want v=1 d=%h r=%b t=%b",
                         h, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.timeout);
            end
            if (h < hold) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rsp_drop: rsp_valid got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        idle_slave();
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_during: valids/readies got %b want 000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || hung !== 1'b0 || rsp_rdata !== '0
            || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: ready=%b busy=%b hung=%b d=%h r=%b t=%b want 1 0 0 0 00 0",
                     cmd_ready, busy, hung, rsp_rdata, rsp_resp, rsp_timeout);
        end
    endtask

    task automatic test_write_basic();
        idle_slave();
        awready = 1'b1; wready = 1'b1;
        send_cmd(1'b1, 32'h010, 32'hDEADBEEF);
        exp_q.push_back('{rdata: 32'h0, resp: 2'b00, timeout: 1'b0});
        n_cmp++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h010 || wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL wr_req: awv=%b wv=%b awaddr=%h wdata=%h want 1 1 00000010 deadbeef",
                     awvalid, wvalid, awaddr, wdata);
        end
        tick();
        n_cmp++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_resp: awv=%b wv=%b bready=%b want 0 0 1", awvalid, wvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_latency: rsp_valid at cycle 3 got %b want 1", rsp_valid);
        end
        collect_rsp(0);
    endtask

    task automatic test_write_late_w();
        idle_slave();
        awready = 1'b1;
        send_cmd(1'b1, 32'h044, 32'hCAFE0001);
        exp_q.push_back('{rdata: 32'h0, resp: 2'b00, timeout: 1'b0});
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL wr_late_hold[%0d]: awv=%b wv=%b bready=%b want 0 1 0",
                         i, awvalid, wvalid, bready);
            end
            tick();
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        n_cmp++;
        if (wvalid !== 1'b0 || bready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_late_w_done: wv=%b bready=%b want 0 1", wvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        collect_rsp(0);
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_late_single: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_delayed();
        idle_slave();
        arready = 1'b1;
        send_cmd(1'b0, 32'h020, 32'h0);
        exp_q.push_back('{rdata: 32'h12345678, resp: 2'b00, timeout: 1'b0});
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h020 || awvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rd_req: arv=%b araddr=%h awv=%b want 1 00000020 0", arvalid, araddr, awvalid);
        end
        tick();
        arready = 1'b0;
        n_cmp++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rd_data: arv=%b rready=%b want 0 1", arvalid, rready);
        end
        tick(); tick();
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFFFFFF;
        collect_rsp(3);
    endtask

    task automatic test_back_to_back_slverr();
        idle_slave();
        arready = 1'b1;
        send_cmd(1'b0, 32'h030, 32'h0);
        exp_q.push_back('{rdata: 32'hBAD0BAD0, resp: 2'b10, timeout: 1'b0});
        tick();
        rvalid = 1'b1; rdata = 32'hBAD0BAD0; rresp = 2'b10;
        tick();
        rvalid = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rd_latency: rsp_valid at cycle 3 got %b want 1", rsp_valid);
        end
        collect_rsp(0);
        n_cmp++;
        if (hung !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL slverr_no_hang: hung=%b cmd_ready=%b want 0 1", hung, cmd_ready);
        end
        rresp = 2'b00;
        send_cmd(1'b0, 32'h034, 32'h0);
        exp_q.push_back('{rdata: 32'h0000A5A5, resp: 2'b00, timeout: 1'b0});
        tick();
        rvalid = 1'b1; rdata = 32'h0000A5A5;
        tick();
        rvalid = 1'b0;
        collect_rsp(1);
    endtask

    task automatic test_reset_mid_write();
        idle_slave();
        awready = 1'b1; wready = 1'b1;
        send_cmd(1'b1, 32'h050, 32'h11112222);
        tick();
        n_cmp++;
        if (bready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_pre: bready got %b want 1", bready);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_rst_async: valids/readies got %b want 000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        tick();
        reset_n = 1'b1;
        bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_rst_after[%0d]: rsp_valid=%b cmd_ready=%b bready=%b want 0 1 0",
                         i, rsp_valid, cmd_ready, bready);
            end
        end
        bvalid = 1'b0;
    endtask

    task automatic test_timeout();
        idle_slave();
        send_cmd(1'b0, 32'h060, 32'h0);
        exp_q.push_back('{rdata: 32'h0, resp: 2'b10, timeout: 1'b1});
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL to_wait[%0d]: arv=%b rsp_valid=%b want 1 0", i, arvalid, rsp_valid);
            end
            tick();
        end
        n_cmp++;
        if (arvalid !== 1'b0 || rready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL to_abort: arv=%b rready=%b want 0 0", arvalid, rready);
        end
        collect_rsp(1);
        cmd_valid = 1'b1; cmd_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (hung !== 1'b1 || cmd_ready !== 1'b0 || arvalid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL to_hung[%0d]: hung=%b cmd_ready=%b arv=%b busy=%b want 1 0 0 1",
                         i, hung, cmd_ready, arvalid, busy);
            end
            tick();
        end
        cmd_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (hung !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL to_cleared: hung=%b cmd_ready=%b want 0 1", hung, cmd_ready);
        end
    endtask

    // Run all scenarios in order and report.
    initial begin
        test_reset();
        test_write_basic();
        test_write_late_w();
        test_read_delayed();
        test_back_to_back_slverr();
        test_reset_mid_write();
        test_timeout();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_cfg_sequencer.md
AXIL_CFG_SEQUENCER -- requirements
Module: axil_cfg_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default CGRA_AXI_ADDR_WIDTH, AXI address width; DATA_WIDTH, default CGRA_AXI_DATA_WIDTH, AXI data width; TIMEOUT_CYCLES, default 1023, abort threshold.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 clock; reset_n in 1 async active-low reset.
REQ-003 Command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_WIDTH; cmd_wdata in DATA_WIDTH.
REQ-004 Response ports SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_WIDTH; rsp_resp out 2 (AXI code); rsp_timeout out 1.
REQ-005 AXI4-lite master ports SHALL be: awaddr out ADDR_WIDTH; awvalid out 1; awready in 1; wdata out DATA_WIDTH; wvalid out 1; wready in 1; bresp in 2; bvalid in 1; bready out 1; araddr out ADDR_WIDTH; arvalid out 1; arready in 1; rdata in DATA_WIDTH; rresp in 2; rvalid in 1; rready out 1.
REQ-006 Status ports SHALL be: busy out 1 (state != IDLE); hung out 1 (sticky timeout flag).

Function
REQ-007 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP, HUNG.
REQ-008 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready and its fields are registered.
REQ-009 Accepted write -> WR_REQ next cycle, awvalid=wvalid=1 registered with awaddr=cmd_addr, wdata=cmd_wdata.
REQ-010 In WR_REQ, awvalid and wvalid SHALL each drop independently the cycle after their own handshake; either order, or same-cycle, SHALL be accepted.
REQ-011 When both AW and W have completed, state -> WR_RESP with bready=1; on bvalid && bready, bresp is captured, rsp_rdata=0, state -> RSP.
REQ-012 Accepted read -> RD_REQ with arvalid=1, araddr=cmd_addr; on arready -> RD_DATA with rready=1; on rvalid capture rdata/rresp, state -> RSP.
REQ-013 In RSP, rsp_valid=1 with stable payload until rsp_ready; on handshake -> IDLE; no new command accepted in the same cycle (min 1 idle cycle between commands).
REQ-014 Minimum latency with always-ready slave: command accept to rsp_valid = 3 cycles for both read and write.
REQ-015 A cycle counter SHALL clear on command accept and increment every cycle in WR_REQ, WR_RESP, RD_REQ, RD_DATA; reaching TIMEOUT_CYCLES SHALL drop all AXI valid/ready outputs and go to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-016 After a timeout response handshake, state SHALL go to HUNG (not IDLE); hung=1, cmd_ready=0 until reset.
REQ-017 AXI valids SHALL never depend combinationally on AXI readies; all AXI outputs registered.
REQ-018 Non-OKAY bresp/rresp SHALL be passed through unchanged with rsp_timeout=0 and no transition to HUNG.

Reset
REQ-019 On reset_n low, asynchronously: state=IDLE, all valid/ready outputs 0 except cmd_ready (1 after reset release in IDLE), rsp_* data 0, counter 0, hung=0, busy=0.
REQ-020 Reset mid-transaction SHALL abandon it with no response emitted.

Structure
REQ-021 State enum and AXI response code constants (OKAY=0, SLVERR=2) SHALL live in global_buffer_param alongside CGRA_AXI_* widths.
REQ-022 The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-023 Write addr 0x010 data 0xDEADBEEF, slave ready always, bresp=0 -> aw/w valid cycle 1, rsp_valid cycle 3, rsp_resp=0.
REQ-024 Write with wready 4 cycles after awready -> awvalid drops after AW handshake, wvalid held until wready, single response.
REQ-025 Read addr 0x020, slave returns rdata=0x12345678 rresp=0 after 2-cycle rvalid delay -> rsp_rdata=0x12345678 held while rsp_ready=0 for 3 cycles.
REQ-026 TIMEOUT_CYCLES=8, slave never asserts arready -> rsp_timeout=1, rsp_resp=2, then hung=1 and cmd_ready=0 until reset.
REQ-027 Read with rresp=2 -> rsp_resp=2, rsp_timeout=0, next command accepted.
REQ-028 reset_n pulsed low during WR_RESP -> all AXI valids/readies 0 immediately, no rsp_valid, cmd_ready=1 after release.
